// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, width/parity constants
// and bit-decision helpers, common to the receiver and transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int UART_DATA_BITS_MIN = 5;
   localparam int UART_DATA_BITS_MAX = 8;
   localparam int UART_DATA_BITS_DEF = 8;

   localparam logic UART_PAR_EVEN = 1'b0;
   localparam logic UART_PAR_ODD  = 1'b1;

   // 16x oversampling: samples at ticks 7 and 8, decision at tick 9
   localparam logic [3:0] UART_TICK_S0     = 4'd7;
   localparam logic [3:0] UART_TICK_S1     = 4'd8;
   localparam logic [3:0] UART_TICK_DECIDE = 4'd9;

   function automatic logic maj3(input logic a, input logic b,
                                 input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
// Both flops reset to 1 (idle level of a serial line).
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Double-register the async input into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted bits, optional
// parity, valid/ready output with frame/parity/overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS_DEF,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_en_16x,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int W_DATA =
      (DATA_BITS < UART_DATA_BITS_MIN) ? UART_DATA_BITS_MIN :
      (DATA_BITS > UART_DATA_BITS_MAX) ? UART_DATA_BITS_MAX :
      DATA_BITS;
   localparam logic [2:0] LAST_BIT = 3'(W_DATA - 1);
   localparam logic PAR_SENSE =
      (PARITY_ODD != 0) ? UART_PAR_ODD : UART_PAR_EVEN;
   localparam logic HAS_PAR = (PARITY_EN != 0);

   uart_state_t          r_state;
   uart_state_t          w_next;
   logic                 w_rxd_s;
   logic                 r_rxd_d;
   logic [3:0]           r_tick;
   logic [2:0]           r_bitcnt;
   logic                 r_s7;
   logic                 r_s8;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_pend;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   logic w_fall;
   logic w_tick7;
   logic w_tick8;
   logic w_tick9;
   logic w_vote;
   logic w_par_exp;
   logic w_deliver;
   logic w_ferr;
   logic w_perr;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rxd),
      .o_q   (w_rxd_s)
   );

   assign w_fall    = r_rxd_d & ~w_rxd_s;
   assign w_tick7   = baud_en_16x & (r_tick == UART_TICK_S0);
   assign w_tick8   = baud_en_16x & (r_tick == UART_TICK_S1);
   assign w_tick9   = baud_en_16x & (r_tick == UART_TICK_DECIDE);
   assign w_vote    = maj3(r_s7, r_s8, w_rxd_s);
   assign w_par_exp = (^r_shift) ^ PAR_SENSE;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state: bits advance only on the tick-9 decision
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_fall) w_next = ST_START;
         ST_START:  if (w_tick9) w_next = w_vote ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (w_tick9 && (r_bitcnt == LAST_BIT))
               w_next = HAS_PAR ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_tick9) w_next = ST_STOP;
         ST_STOP:   if (w_tick9) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // FSM outputs: end-of-frame outcome strobes
   always_comb begin
      w_deliver = 1'b0;
      w_ferr    = 1'b0;
      w_perr    = 1'b0;
      if (r_state == ST_STOP && w_tick9) begin
         w_ferr    = ~w_vote;
         w_perr    = w_vote & r_par_pend;
         w_deliver = w_vote & ~r_par_pend;
      end
   end

   // Bit timing, vote samples, shift register and parity tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxd_d    <= 1'b1;
         r_tick     <= '0;
         r_bitcnt   <= '0;
         r_s7       <= 1'b1;
         r_s8       <= 1'b1;
         r_shift    <= '0;
         r_par_pend <= 1'b0;
      end else begin
         r_rxd_d <= w_rxd_s;
         if (r_state == ST_IDLE) begin
            r_tick     <= '0;
            r_bitcnt   <= '0;
            r_par_pend <= 1'b0;
         end else if (baud_en_16x) begin
            r_tick <= r_tick + 4'd1;
         end
         if (w_tick7) r_s7 <= w_rxd_s;
         if (w_tick8) r_s8 <= w_rxd_s;
         if (r_state == ST_DATA && w_tick9) begin
            r_shift  <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (r_state == ST_PARITY && w_tick9 && (w_vote != w_par_exp))
            r_par_pend <= 1'b1;
      end
   end

   // Output word, valid/ready handshake and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err  <= w_ferr;
         r_parity_err <= w_perr;
         r_overrun    <= w_deliver & r_rx_valid & ~rx_ready;
         if (w_deliver) begin
            if (!r_rx_valid || rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign overrun    = r_overrun;

endmodule
